// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - runtime-programmable modulo-N up/down counter with load and terminal count
// Optional MODN_WRAP_CNT_EN adds a saturating 8-bit wrap counter output (wrap_cnt).
module mod_n_updown_counter #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
`ifdef MODN_WRAP_CNT_EN
  output logic [7:0]       wrap_cnt,
`endif
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  // DEFAULT_MOD may equal 2**WIDTH, so only its terminal value M-1 is kept.
  localparam logic [WIDTH-1:0] DEF_MAX = WIDTH'(DEFAULT_MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] max_val;
  logic             at_top;
  logic             at_zero;

  assign max_val = (mod_val >= TWO) ? (mod_val - ONE) : DEF_MAX;
  assign at_top  = (count_q >= max_val);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (enable) begin
      if (up_dn) begin
        count_d = at_top ? '0 : (count_q + ONE);
      end else if (at_zero || (count_q > max_val)) begin
        count_d = max_val;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated by rst_n so a down-counting stage at zero does not flag a wrap while held in reset.
  assign tc    = rst_n & enable & ~load & ((up_dn & at_top) | (~up_dn & at_zero));
  assign count = count_q;

`ifdef MODN_WRAP_CNT_EN
  logic [7:0] wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (load) begin
      wrap_d = '0;
    end else if (tc && (wrap_q != 8'hFF)) begin
      wrap_d = wrap_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - randomized self-checking bench for mod_n_updown_counter
module tb_mod_n_updown_counter;
  localparam int WIDTH       = 4;
  localparam int DEFAULT_MOD = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] count;
  logic             tc;

  int n_checks = 0;
  int n_pass   = 0;
  int mcnt     = 0;

  always #5 clk = ~clk;

`ifdef MODN_WRAP_CNT_EN
  logic [7:0]       wrap_cnt;
  logic [WIDTH-1:0] s1_count;
  logic             s1_tc;
  logic [7:0]       s1_wrap;
  int               mwrap = 0;
  int               s1cnt = 0;

  mod_n_updown_counter #(.WIDTH(WIDTH), .DEFAULT_MOD(DEFAULT_MOD)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mod_val(mod_val), .count(count), .wrap_cnt(wrap_cnt), .tc(tc)
  );

  mod_n_updown_counter #(.WIDTH(WIDTH), .DEFAULT_MOD(DEFAULT_MOD)) u_stage1 (
    .clk(clk), .rst_n(rst_n), .enable(tc), .up_dn(1'b1), .load(1'b0),
    .load_val('0), .mod_val('0), .count(s1_count), .wrap_cnt(s1_wrap), .tc(s1_tc)
  );
`else
  mod_n_updown_counter #(.WIDTH(WIDTH), .DEFAULT_MOD(DEFAULT_MOD)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mod_val(mod_val), .count(count), .tc(tc)
  );
`endif

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int eff_mod(input int mv);
    return (mv >= 2) ? mv : DEFAULT_MOD;
  endfunction

  function automatic int exp_tc(input int cnt, input int en, input int ud, input int ld, input int mv);
    int m;
    m = eff_mod(mv);
    return (en != 0 && ld == 0 && ((ud != 0 && cnt >= m - 1) || (ud == 0 && cnt == 0))) ? 1 : 0;
  endfunction

  function automatic int next_cnt(input int cnt, input int en, input int ud, input int ld,
                                  input int lv, input int mv);
    int m;
    m = eff_mod(mv);
    if (ld != 0) return (lv <= m - 1) ? lv : m - 1;
    if (en == 0) return cnt;
    if (ud != 0) return (cnt >= m - 1) ? 0 : (cnt + 1) % m;
    if (cnt == 0 || cnt > m - 1) return m - 1;
    return cnt - 1;
  endfunction

  // Drive inputs just after a rising edge, check at the falling edge, then advance the model.
  task automatic step(input int en, input int ud, input int ld, input int lv, input int mv);
    int t;
    enable   = (en != 0);
    up_dn    = (ud != 0);
    load     = (ld != 0);
    load_val = lv[WIDTH-1:0];
    mod_val  = mv[WIDTH-1:0];
    @(negedge clk);
    t = exp_tc(mcnt, en, ud, ld, mv);
    check_eq("count", int'(count), mcnt);
    check_eq("tc", int'(tc), t);
`ifdef MODN_WRAP_CNT_EN
    check_eq("wrap_cnt", int'(wrap_cnt), mwrap);
    check_eq("stage1_count", int'(s1_count), s1cnt);
`endif
    @(posedge clk);
`ifdef MODN_WRAP_CNT_EN
    s1cnt = next_cnt(s1cnt, t, 1, 0, 0, 0);
    if (ld != 0) mwrap = 0;
    else if (t != 0 && mwrap < 255) mwrap = mwrap + 1;
`endif
    mcnt = next_cnt(mcnt, en, ud, ld, lv, mv);
    #1;
  endtask

  task automatic model_reset();
    mcnt = 0;
`ifdef MODN_WRAP_CNT_EN
    mwrap = 0;
    s1cnt = 0;
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    up_dn    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    mod_val  = '0;
    @(negedge clk);
    check_eq("reset_count", int'(count), 0);
    check_eq("reset_tc", int'(tc), 0);
    #2;
    enable = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Default modulus, count up through one full wrap
    for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 0);
`ifdef MODN_WRAP_CNT_EN
    // Cascade: 25 edges from zero leave stage1/stage0 at 2/5
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) step(1, 1, 0, 0, 0);
    check_eq("cascade_s0", int'(count), 5);
    check_eq("cascade_s1", int'(s1_count), 2);
    check_eq("cascade_wrap", int'(wrap_cnt), 2);
`endif

    // Down wrap with M=6 from 2
    step(0, 1, 1, 2, 6);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 6);

    // Load, clamp, and load overriding enable
    step(1, 1, 1, 3, 6);
    step(1, 1, 1, 12, 6);
    step(0, 1, 0, 0, 6);

    // Hold while direction and modulus change
    step(0, 1, 1, 4, 6);
    step(0, 1, 0, 0, 6);
    step(0, 0, 0, 0, 2);
    step(0, 1, 0, 0, 3);

    // Asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_count", int'(count), 0);
    check_eq("async_rst_tc", int'(tc), 0);
    model_reset();
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 0, 0, 6);

    // Modulus shrink below the current count
    step(0, 1, 1, 8, 10);
    step(1, 1, 0, 0, 4);
    step(0, 1, 1, 8, 10);
    step(1, 0, 0, 0, 4);
    step(0, 0, 0, 0, 4);

    // Randomized traffic, including out-of-range moduli and oversized loads
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Parametrised, runtime-programmable modulo-N counter; the successor to the fixed mod-10 counter. Adds up/down direction, synchronous load, a runtime modulus with a fallback default, and a combinational terminal-count output for cascading counter stages (e.g. digit chains, timers). Sits in the sequential counters library as the general-purpose counter primitive.

Parameters:
WIDTH, 4, counter/modulus/load width in bits (2..16)
DEFAULT_MOD, 10, modulus used when mod_val is out of range; legal range 2..2**WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  count enable; counter holds when 0
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded on load
mod_val  input  WIDTH  runtime modulus M
count  output  WIDTH  current count, registered
tc  output  1  terminal count / carry-borrow, combinational

Behaviour:
- Clocking: one clock (clk); reset asynchronous, active-low (rst_n). rst_n=0 -> count=0 immediately, independent of clk; tc=0 while in reset.
- Effective modulus M: mod_val if mod_val >= 2, else DEFAULT_MOD. M is evaluated every cycle with no registering, so a change takes effect on the next edge.
- Valid range 0..M-1.
- Priority per rising edge: reset > load > enable > hold.
- load=1: count <= load_val if load_val <= M-1, else count <= M-1. Load overrides enable and up_dn.
- enable=1, load=0, up_dn=1: count >= M-1 -> 0, otherwise count+1.
- enable=1, load=0, up_dn=0: count==0 -> M-1; count > M-1 -> M-1; otherwise count-1.
- enable=0, load=0: count holds. Direction and modulus changes have no effect while holding.
- tc = enable & ~load & ((up_dn & count >= M-1) | (~up_dn & count==0)).
  - tc is high exactly in the cycle whose edge wraps the counter.
  - Cascade: drive the next stage's enable with this stage's tc.
- Mid-count modulus reduction below the current count:
  - Up count wraps to 0 on the next enabled edge, with tc=1.
  - Down count clamps to M-1, with tc=0.
- Latency: count updates one edge after the inputs are sampled. tc has zero-cycle latency from count and the inputs.
- All arithmetic is WIDTH bits. M-1 never underflows because M >= 2.
- Reset released mid-operation: counting restarts from 0 on the first enabled edge after rst_n rises.

Optional Feature:
Macro MODN_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_cnt, 8 bits, reset to 0.
  - Increments on every edge where tc=1, and saturates at 255.
  - Cleared to 0 by load, with load taking priority.
- Not defined: wrap_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then default: rst_n=0 for 12 ns, mod_val=0 (DEFAULT_MOD=10), enable=1, up_dn=1 -> count 0,1,...,9,0; tc=1 only while count=9.
- Down wrap: mod_val=6, up_dn=0 from count=2 -> 2,1,0,5,4; tc=1 while count=0.
- Load and clamp: mod_val=6, load=1 with load_val=3 -> count=3. Then load_val=12 -> count=5. Load with enable=1 gives no extra increment.
- Hold and async reset: enable=0 for 3 edges at count=4 -> count stays 4, tc=0. Drop rst_n between edges -> count=0 before the next edge.
- Modulus shrink: count=8 with M=10, set mod_val=4, up_dn=1 -> tc=1, next count=0. Repeat with up_dn=0 -> next count=3.
- Cascade (MODN_WRAP_CNT_EN defined): two instances, M=10 each, stage-1 enable=stage-0 tc -> after 25 edges counts read 2/5; stage-0 wrap_cnt=2.
